series_eval_engine: RTL and testbench

- Parametrised successor of the fixed-term tangent controller: a complete Taylor-series evaluator with its own controller and datapath.
- Evaluates E = sum over k of coef[k]·T_k. Mode ODD: T_k = x^(2k+1) (tan/sin/atan). Mode ALL: T_k = x^k (exp/cos-style).
- Term count is runtime-selectable; width, fraction and maximum depth are parameters.
- Coefficients come from an external combinational ROM indexed by mode and term.
- Sits beside the existing function units and is driven by the same start/ready/busy handshake.

---
 rtl/series_eval_pkg.sv | 47 ++++
 rtl/series_eval_cntl.sv | 114 +++++++++++
 rtl/series_eval_engine.sv | 110 +++++++++++
 tb/tb_series_eval_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/series_eval_pkg.sv
// Shared types, mode encodings and saturating fixed-point helpers for the series evaluator.
// Helpers operate on sign-extended operands of up to 32 bits.
package series_eval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    INIT,
    MKSTEP,
    MULC,
    ACC,
    MULT,
    DONE
  } state_t;

  localparam logic MODE_ODD = 1'b0;
  localparam logic MODE_ALL = 1'b1;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Full product, arithmetic shift by frac (floor), then saturate.
  function automatic logic signed [63:0] sat_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w,
                                                 input int unsigned frac);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return sat_clamp(p >>> frac, w);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    return sat_clamp(64'(a) + 64'(b), w);
  endfunction

endpackage

// File: rtl/series_eval_cntl.sv
// Sequencer for the series evaluator: handshake FSM, term counter and datapath load strobes.
module series_eval_cntl
  import series_eval_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned KW        = $clog2(MAX_TERMS),
  parameter int unsigned NW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [NW-1:0] i_n_terms,
  output logic [KW-1:0] o_k,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ld_init_c,
  output logic          o_ld_step_c,
  output logic          o_ld_s_c,
  output logic          o_ld_e_c,
  output logic          o_ld_t_c,
  output logic          o_ld_res_c
);

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_k;
  logic [NW-1:0] r_n_eff;
  logic [NW-1:0] w_n_clamp;
  logic          w_last;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  // Zero terms behaves as one; oversize requests are capped at the table depth.
  always_comb begin
    w_n_clamp = i_n_terms;
    if (i_n_terms == '0) begin
      w_n_clamp = NW'(1);
    end else if (i_n_terms > NW'(MAX_TERMS)) begin
      w_n_clamp = NW'(MAX_TERMS);
    end
  end

  assign w_last = (NW'(r_k) == (r_n_eff - NW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = HOLD;
      HOLD:    if (!i_start) w_next = INIT;
      INIT:    w_next = MKSTEP;
      MKSTEP:  w_next = MULC;
      MULC:    w_next = ACC;
      ACC:     w_next = w_last ? DONE : MULT;
      MULT:    w_next = MULC;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_ld_init_c = 1'b0;
    o_ld_step_c = 1'b0;
    o_ld_s_c    = 1'b0;
    o_ld_e_c    = 1'b0;
    o_ld_t_c    = 1'b0;
    o_ld_res_c  = 1'b0;
    case (r_state)
      INIT:    o_ld_init_c = 1'b1;
      MKSTEP:  o_ld_step_c = 1'b1;
      MULC:    o_ld_s_c    = 1'b1;
      ACC:     o_ld_e_c    = 1'b1;
      MULT:    o_ld_t_c    = 1'b1;
      DONE:    o_ld_res_c  = 1'b1;
      default: ;
    endcase
  end

  // Term index, latched depth and status flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_n_eff <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_k     <= '0;
        r_n_eff <= w_n_clamp;
      end else if (r_state == ACC && !w_last) begin
        r_k <= r_k + KW'(1);
      end else if (r_state == DONE) begin
        r_k <= '0;
      end
      r_ready <= (w_next == IDLE);
      r_busy  <= (w_next == INIT) || (w_next == MKSTEP) || (w_next == MULC) ||
                 (w_next == ACC) || (w_next == MULT);
      r_done  <= (w_next == DONE);
    end
  end

  assign o_k     = r_k;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/series_eval_engine.sv
// Taylor-series evaluator: E = sum coef[k]*T_k with T_k = x^(2k+1) (ODD) or x^k (ALL),
// one shared saturating multiplier, coefficients from an external combinational ROM.
module series_eval_engine
  import series_eval_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC      = 12,
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned KW        = $clog2(MAX_TERMS),
  parameter int unsigned NW        = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [NW-1:0]    n_terms,
  input  logic [WIDTH-1:0] x_in,
  output logic [KW-1:0]    coef_addr,
  output logic             coef_mode,
  input  logic [WIDTH-1:0] coef_data,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

  logic                    w_ld_init_c;
  logic                    w_ld_step_c;
  logic                    w_ld_s_c;
  logic                    w_ld_e_c;
  logic                    w_ld_t_c;
  logic                    w_ld_res_c;
  logic signed [WIDTH-1:0] r_x;
  logic                    r_mode;
  logic signed [WIDTH-1:0] r_t;
  logic signed [WIDTH-1:0] r_step;
  logic signed [WIDTH-1:0] r_s;
  logic signed [WIDTH-1:0] r_e;
  logic signed [WIDTH-1:0] r_result;
  logic signed [WIDTH-1:0] w_mul_a;
  logic signed [WIDTH-1:0] w_mul_b;
  logic signed [WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0] w_sum;

  series_eval_cntl #(
    .MAX_TERMS(MAX_TERMS),
    .KW       (KW),
    .NW       (NW)
  ) u_cntl (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_n_terms  (n_terms),
    .o_k        (coef_addr),
    .o_ready    (ready),
    .o_busy     (busy),
    .o_done     (done),
    .o_ld_init_c(w_ld_init_c),
    .o_ld_step_c(w_ld_step_c),
    .o_ld_s_c   (w_ld_s_c),
    .o_ld_e_c   (w_ld_e_c),
    .o_ld_t_c   (w_ld_t_c),
    .o_ld_res_c (w_ld_res_c)
  );

  // Shared multiplier operands: x*x in MKSTEP, T*coef in MULC, T*STEP otherwise.
  always_comb begin
    w_mul_a = r_t;
    w_mul_b = r_step;
    if (w_ld_step_c) begin
      w_mul_a = r_x;
      w_mul_b = r_x;
    end else if (w_ld_s_c) begin
      w_mul_b = $signed(coef_data);
    end
  end

  assign w_prod = WIDTH'(sat_mul(32'(w_mul_a), 32'(w_mul_b), WIDTH, FRAC));
  assign w_sum  = WIDTH'(sat_add(32'(r_e), 32'(r_s), WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_mode   <= MODE_ODD;
      r_t      <= '0;
      r_step   <= '0;
      r_s      <= '0;
      r_e      <= '0;
      r_result <= '0;
    end else begin
      if (w_ld_init_c) begin
        r_x    <= $signed(x_in);
        r_mode <= mode;
        r_t    <= (mode == MODE_ODD) ? $signed(x_in) : ONE;
        r_e    <= '0;
      end
      if (w_ld_step_c) r_step <= (r_mode == MODE_ALL) ? r_x : w_prod;
      if (w_ld_s_c)    r_s    <= w_prod;
      if (w_ld_e_c)    r_e    <= w_sum;
      if (w_ld_t_c)    r_t    <= w_prod;
      if (w_ld_res_c)  r_result <= r_e;
    end
  end

  assign coef_mode = r_mode;
  assign result    = r_result;

endmodule

// File: tb/tb_series_eval_engine.sv
// Scoreboard bench for series_eval_engine: reference model results queued at launch, compared at done.
module tb_series_eval_engine;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned FRAC      = 12;
  localparam int unsigned MAX_TERMS = 8;
  localparam int unsigned KW        = 3;
  localparam int unsigned NW        = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [NW-1:0]    n_terms;
  logic [WIDTH-1:0] x_in;
  logic [KW-1:0]    coef_addr;
  logic             coef_mode;
  logic [WIDTH-1:0] coef_data;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic signed [WIDTH-1:0] rom [MAX_TERMS];
  logic signed [WIDTH-1:0] exp_q [$];
  int                      addr_seq [$];
  int                      checks = 0;
  int                      errors = 0;

  always #5 clk = ~clk;

  assign coef_data = rom[coef_addr];

  series_eval_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .MAX_TERMS(MAX_TERMS), .KW(KW), .NW(NW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_terms(n_terms), .x_in(x_in),
    .coef_addr(coef_addr), .coef_mode(coef_mode), .coef_data(coef_data),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int m_sat(longint v);
    if (v > 64'sd32767) return 32767;
    if (v < -64'sd32768) return -32768;
    return int'(v);
  endfunction

  function automatic int m_mul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return m_sat(p >>> FRAC);
  endfunction

  function automatic int model(logic md, int n, int x);
    int ne, t, st, e;
    ne = (n == 0) ? 1 : ((n > int'(MAX_TERMS)) ? int'(MAX_TERMS) : n);
    t  = md ? 4096 : x;
    st = md ? x : m_mul(x, x);
    e  = 0;
    for (int k = 0; k < ne; k++) begin
      e = m_sat(longint'(e) + longint'(m_mul(t, int'(rom[k]))));
      if (k < ne - 1) t = m_mul(t, st);
    end
    return e;
  endfunction

  // Drive a start pulse and queue the model's answer.
  task automatic launch(input logic md, input int n, input int x);
    @(negedge clk);
    mode    = md;
    n_terms = NW'(n);
    x_in    = WIDTH'(x);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(WIDTH'(model(md, n, x)));
  endtask

  // Wait for done, counting busy cycles; scrambles inputs after INIT and optionally pokes start.
  task automatic wait_done(input int poke, output int bcnt, output int dcnt, output bit tmo);
    bcnt = 0;
    dcnt = 0;
    tmo  = 1'b1;
    addr_seq.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        bcnt++;
        if (addr_seq.size() == 0 || addr_seq[$] != int'(coef_addr))
          addr_seq.push_back(int'(coef_addr));
        if (bcnt == 2) begin
          x_in    = WIDTH'($urandom);
          mode    = ~mode;
          n_terms = NW'($urandom);
        end
        if (bcnt == poke) start = 1'b1;
      end
      if (done) begin
        dcnt++;
        tmo = 1'b0;
        @(negedge clk);
        if (done) dcnt++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; n_terms = '0; x_in = '0;
    for (int i = 0; i < int'(MAX_TERMS); i++) rom[i] = '0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
    end
    checks++;
    if (result !== '0 || coef_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: result=%0d coef_addr=%0d, want 0 0", result, coef_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_mode();
    int b, d; bit t;
    logic signed [WIDTH-1:0] e;
    rom[0] = 16'sd4096; rom[1] = 16'sd4096; rom[2] = 16'sd2048; rom[3] = 16'sd683;
    launch(1'b1, 4, 4096);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'd10923 || result !== e) begin
      errors++;
      $display("FAIL all_n4_result: got %0d timeout=%0d, want 10923 (model %0d)", $signed(result), t, e);
    end
    checks++;
    if (b != 13 || d != 1) begin
      errors++;
      $display("FAIL all_n4_timing: busy=%0d done=%0d, want 13 1", b, d);
    end
    checks++;
    if (coef_mode !== 1'b1 || coef_addr !== '0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL all_n4_post: coef_mode=%b coef_addr=%0d ready=%b, want 1 0 1", coef_mode, coef_addr, ready);
    end
  endtask

  task automatic test_odd_mode();
    int b, d; bit t;
    logic signed [WIDTH-1:0] e;
    rom[0] = 16'sd4096; rom[1] = 16'sd1365;
    launch(1'b0, 1, 2048);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'd2048 || result !== e || b != 4) begin
      errors++;
      $display("FAIL odd_n1: got %0d busy=%0d, want 2048 busy=4", $signed(result), b);
    end
    launch(1'b0, 2, 2048);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'd2218 || result !== e || b != 7 || coef_mode !== 1'b0) begin
      errors++;
      $display("FAIL odd_n2: got %0d busy=%0d mode=%b, want 2218 busy=7 mode=0", $signed(result), b, coef_mode);
    end
  endtask

  task automatic test_saturation();
    int b, d; bit t;
    logic signed [WIDTH-1:0] e;
    rom[0] = 16'sd4096; rom[1] = 16'sd4096; rom[2] = 16'sd4096;
    launch(1'b1, 3, 28672);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'd32767 || result !== e) begin
      errors++;
      $display("FAIL sat_pos: got %0d, want 32767", $signed(result));
    end
    rom[0] = 16'sd0; rom[1] = 16'sd0; rom[2] = -16'sd4096;
    launch(1'b1, 3, -28672);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== e) begin
      errors++;
      $display("FAIL sat_neg_mirror: got %0d, want %0d", $signed(result), e);
    end
    rom[2] = -16'sd8192;
    launch(1'b1, 3, -28672);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'h8000 || result !== e) begin
      errors++;
      $display("FAIL sat_neg_floor: got %0d, want -32768", $signed(result));
    end
  endtask

  task automatic test_handshake();
    int b, d; bit t, bad;
    logic signed [WIDTH-1:0] e;
    rom[0] = 16'sd4096; rom[1] = 16'sd2048; rom[2] = 16'sd1024; rom[3] = 16'sd512;
    @(negedge clk);
    mode = 1'b1; n_terms = NW'(4); x_in = WIDTH'(3000); start = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_state: ready=%b busy=%b while start held, want 0 0", ready, busy);
    end
    start = 1'b0;
    exp_q.push_back(WIDTH'(model(1'b1, 4, 3000)));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: busy=%b one cycle after release, want 1", busy);
    end
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== e || b + 1 != 13) begin
      errors++;
      $display("FAIL hold_run: got %0d busy=%0d, want %0d busy=13", $signed(result), b + 1, e);
    end
    launch(1'b0, 4, 3500);
    wait_done(5, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== e || b != 13 || d != 1) begin
      errors++;
      $display("FAIL busy_poke: got %0d busy=%0d done=%0d, want %0d 13 1", $signed(result), b, d, e);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_poke_idle: engine left IDLE after ignored start");
    end
  endtask

  task automatic test_reset_abort();
    int b, d; bit t, seen;
    logic signed [WIDTH-1:0] e;
    rom[0] = 16'sd4096; rom[1] = 16'sd4096; rom[2] = 16'sd2048; rom[3] = 16'sd683;
    launch(1'b1, 4, 4096);
    b = 0;
    for (int c = 0; c < 50 && b < 6; c++) begin
      @(negedge clk);
      if (busy) b++;
    end
    e = exp_q.pop_front();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || coef_addr !== '0) begin
      errors++;
      $display("FAIL abort_async: ready=%b busy=%b done=%b result=%0d addr=%0d, want 1 0 0 0 0",
               ready, busy, done, result, coef_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: activity seen after abort (done/busy), want none");
    end
    launch(1'b1, 4, 4096);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'd10923 || result !== e || b != 13) begin
      errors++;
      $display("FAIL abort_rerun: got %0d busy=%0d, want 10923 busy=13", $signed(result), b);
    end
  endtask

  task automatic test_term_clamp();
    int b, d; bit t, bad;
    logic signed [WIDTH-1:0] e;
    rom[0] = 16'sd4096;
    launch(1'b0, 0, 2048);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== 16'd2048 || result !== e || b != 4) begin
      errors++;
      $display("FAIL n0_as_n1: got %0d busy=%0d, want 2048 busy=4", $signed(result), b);
    end
    for (int i = 0; i < int'(MAX_TERMS); i++) rom[i] = WIDTH'(4096 - 400 * i);
    launch(1'b1, 15, 2048);
    wait_done(0, b, d, t);
    e = exp_q.pop_front();
    checks++;
    if (t || result !== e || b != 25) begin
      errors++;
      $display("FAIL n15_clamp: got %0d busy=%0d, want %0d busy=25", $signed(result), b, e);
    end
    bad = (addr_seq.size() != int'(MAX_TERMS));
    if (!bad) for (int i = 0; i < int'(MAX_TERMS); i++) if (addr_seq[i] != i) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL n15_addr_seq: %0d distinct addresses seen, want 0..7 in order", addr_seq.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_mode();
    test_odd_mode();
    test_saturation();
    test_handshake();
    test_reset_abort();
    test_term_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
